pb_conditioner: RTL and testbench

Synchronizer, debouncer and edge detector for the push-button bank. It sits directly upstream of the button-stepped state machines, such as the red/green sequencer. It converts raw `pb` bits into clean levels and one-cycle `press`/`release` strobes in the `hz100` domain, so downstream FSMs advance on a clock enable instead of being clocked by a bouncing button. Optional auto-repeat re-fires `press` while a button is held.

---
 rtl/pb_pkg.sv | 20 ++
 rtl/pb_channel.sv | 125 ++++++++++++
 rtl/pb_conditioner.sv | 35 +++
 tb/tb_pb_conditioner.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/pb_pkg.sv
// Shared types and defaults for the push-button conditioner.
package pb_pkg;

   // Per-channel debounce FSM state.
   typedef enum logic [1:0] {
      StIdle,
      StArming,
      StPressed,
      StDisarming
   } pb_state_t;

   localparam int unsigned PB_DEBOUNCE_DEFAULT = 3;
   localparam int unsigned PB_WIDTH_DEFAULT    = 21;

   // Bits needed to hold values 0..n-1, never less than one.
   function automatic int unsigned pb_cnt_bits(int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/pb_channel.sv
// One button channel: 2-flop synchronizer, debounce FSM, hold/repeat counters
// and registered level/press/release outputs.
module pb_channel import pb_pkg::*; #(
   parameter int unsigned DEBOUNCE_TICKS = PB_DEBOUNCE_DEFAULT,
   parameter int unsigned REPEAT_DELAY   = 0,
   parameter int unsigned REPEAT_PERIOD  = 10
) (
   input  logic hz100,
   input  logic reset,
   input  logic pb,
   output logic level,
   output logic press,
   output logic pb_release
);

   localparam int unsigned CntW  = pb_cnt_bits(DEBOUNCE_TICKS + 1);
   localparam int unsigned HoldW = pb_cnt_bits(REPEAT_DELAY + REPEAT_PERIOD + 1);
   localparam int unsigned PerW  = pb_cnt_bits(REPEAT_PERIOD);
   localparam logic [CntW-1:0]  CntLast = CntW'(DEBOUNCE_TICKS - 1);
   localparam logic [HoldW-1:0] HoldRep = HoldW'(REPEAT_DELAY);
   localparam logic [PerW-1:0]  PerLast = PerW'(REPEAT_PERIOD - 1);
   localparam bit RepeatEn = (REPEAT_DELAY != 0);

   logic             s1_q, s_q;
   pb_state_t        state_q, state_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic [HoldW-1:0] hold_q, hold_d;
   logic [PerW-1:0]  per_q, per_d;
   logic             level_q, press_q, rel_q;
   logic             level_d, press_d, rel_d;

   // State, counters, synchronizer and output registers.
   always_ff @(posedge hz100) begin
      if (reset) begin
         s1_q    <= 1'b0;
         s_q     <= 1'b0;
         state_q <= StIdle;
         cnt_q   <= '0;
         hold_q  <= '0;
         per_q   <= '0;
         level_q <= 1'b0;
         press_q <= 1'b0;
         rel_q   <= 1'b0;
      end else begin
         s1_q    <= pb;
         s_q     <= s1_q;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hold_q  <= hold_d;
         per_q   <= per_d;
         level_q <= level_d;
         press_q <= press_d;
         rel_q   <= rel_d;
      end
   end

   // Next-state, counter and strobe decode.
   // With repeat enabled the hold counter stops at REPEAT_DELAY; from then on
   // the period counter paces the repeats, so neither counter ever wraps.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hold_d  = hold_q;
      per_d   = per_q;
      press_d = 1'b0;
      rel_d   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (s_q) begin
               state_d = StArming;
               cnt_d   = CntW'(1);
            end
         end
         StArming: begin
            if (!s_q) begin
               state_d = StIdle;
               cnt_d   = '0;
            end else if (cnt_q == CntLast) begin
               state_d = StPressed;
               hold_d  = '0;
               per_d   = '0;
               press_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StPressed: begin
            if (!s_q) begin
               state_d = StDisarming;
               cnt_d   = CntW'(1);
            end else if (RepeatEn) begin
               if (hold_q != HoldRep) begin
                  hold_d = hold_q + 1'b1;
                  if (hold_d == HoldRep) press_d = 1'b1;
               end else if (per_q == PerLast) begin
                  per_d   = '0;
                  press_d = 1'b1;
               end else begin
                  per_d = per_q + 1'b1;
               end
            end else if (hold_q != '1) begin
               hold_d = hold_q + 1'b1;
            end
         end
         StDisarming: begin
            if (s_q) begin
               state_d = StPressed;
            end else if (cnt_q == CntLast) begin
               state_d = StIdle;
               cnt_d   = '0;
               rel_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
      level_d = (state_d == StPressed) || (state_d == StDisarming);
   end

   assign level      = level_q;
   assign press      = press_q;
   assign pb_release = rel_q;

endmodule

// File: rtl/pb_conditioner.sv
// Push-button bank conditioner: one independent pb_channel per button.
// The release strobe is named pb_release because "release" is a reserved word.
module pb_conditioner import pb_pkg::*; #(
   parameter int unsigned WIDTH          = PB_WIDTH_DEFAULT,
   parameter int unsigned DEBOUNCE_TICKS = PB_DEBOUNCE_DEFAULT,
   parameter int unsigned REPEAT_DELAY   = 0,
   parameter int unsigned REPEAT_PERIOD  = 10
) (
   input  logic             hz100,
   input  logic             reset,
   input  logic [WIDTH-1:0] pb,
   output logic [WIDTH-1:0] level,
   output logic [WIDTH-1:0] press,
   output logic [WIDTH-1:0] pb_release,
   output logic             any_press
);

   for (genvar i = 0; i < WIDTH; i++) begin : g_chan
      pb_channel #(
         .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
         .REPEAT_DELAY   (REPEAT_DELAY),
         .REPEAT_PERIOD  (REPEAT_PERIOD)
      ) u_chan (
         .hz100      (hz100),
         .reset      (reset),
         .pb         (pb[i]),
         .level      (level[i]),
         .press      (press[i]),
         .pb_release (pb_release[i])
      );
   end

   assign any_press = |press;

endmodule

// File: tb/tb_pb_conditioner.sv
// Scoreboard bench: stimulus queues expected strobes, a negedge monitor pops
// and compares whenever either DUT shows press/release/any_press activity.
module tb_pb_conditioner;

   localparam int W = 21;

   logic         hz100 = 1'b0;
   logic         reset = 1'b1;
   logic [W-1:0] pb = '0;
   logic [W-1:0] level, press, pb_release;
   logic         any_press;
   logic [0:0]   pb_r = '0;
   logic [0:0]   level_r, press_r, rel_r;
   logic         any_r;

   pb_conditioner u_dut (
      .hz100      (hz100),
      .reset      (reset),
      .pb         (pb),
      .level      (level),
      .press      (press),
      .pb_release (pb_release),
      .any_press  (any_press)
   );

   pb_conditioner #(
      .WIDTH         (1),
      .REPEAT_DELAY  (20),
      .REPEAT_PERIOD (5)
   ) u_rpt (
      .hz100      (hz100),
      .reset      (reset),
      .pb         (pb_r),
      .level      (level_r),
      .press      (press_r),
      .pb_release (rel_r),
      .any_press  (any_r)
   );

   always #5 hz100 = ~hz100;

   int cyc = 0;
   // Edge counter: after edge n the value is n.
   always @(posedge hz100) cyc <= cyc + 1;

   // Red/green/yellow sequencer stepped by the debounced press of button 1.
   logic [1:0] seq;
   always @(posedge hz100) begin
      if (reset) seq <= 2'd0;
      else if (press[1]) seq <= (seq == 2'd2) ? 2'd0 : seq + 2'd1;
   end

   typedef struct {
      int           cyc;
      int           inst;
      logic [W-1:0] p;
      logic [W-1:0] r;
   } ev_t;

   ev_t exp_q[$];
   int  checks = 0;
   int  errors = 0;

   function automatic logic [W-1:0] bitm(int i);
      logic [W-1:0] one;
      one = W'(1);
      return one << i;
   endfunction

   task automatic expect_ev(int c, int inst, logic [W-1:0] p, logic [W-1:0] r);
      exp_q.push_back('{c, inst, p, r});
   endtask

   task automatic check(string name, logic [W-1:0] act, logic [W-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s cycle %0d: got %h required %h", name, cyc, act, req);
      end
   endtask

   task automatic at(int n);
      while (cyc < n) @(negedge hz100);
   endtask

   task automatic observe(int inst, logic [W-1:0] p, logic [W-1:0] r, logic a);
      ev_t e;
      if (p == '0 && r == '0 && !a) return;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL unexpected_strobe inst %0d cycle %0d: press %h release %h any %b, required none",
                  inst, cyc, p, r, a);
         return;
      end
      e = exp_q.pop_front();
      if (e.cyc != cyc || e.inst != inst || p !== e.p || r !== e.r || a !== (e.p != '0)) begin
         errors++;
         $display("FAIL strobe: got inst %0d cycle %0d press %h release %h any %b, required inst %0d cycle %0d press %h release %h any %b",
                  inst, cyc, p, r, a, e.inst, e.cyc, e.p, e.r, (e.p != '0));
      end
   endtask

   // Monitor: compare every strobe the DUTs present against the queue head.
   always @(negedge hz100) begin
      observe(0, press, pb_release, any_press);
      observe(1, W'(press_r), W'(rel_r), any_r);
   end

   task automatic press_hold(int i);
      int b;
      b = cyc;
      pb[i] = 1'b1;
      expect_ev(b + 5, 0, bitm(i), '0);
      at(b + 8);
      pb[i] = 1'b0;
      expect_ev(b + 13, 0, '0, bitm(i));
      at(b + 15);
   endtask

   initial begin
      int b;
      @(negedge hz100);
      at(2);
      check("reset_level", level, '0);
      check("reset_press", press, '0);
      check("reset_release", pb_release, '0);
      check("reset_rpt_level", W'(level_r), '0);
      reset = 1'b0;

      // Clean press and release on button 1.
      b = cyc;
      pb[1] = 1'b1;
      expect_ev(b + 5, 0, bitm(1), '0);
      at(b + 4);
      check("clean_level_before", level, '0);
      at(b + 5);
      check("clean_level_up", level, bitm(1));
      at(b + 19);
      pb[1] = 1'b0;
      expect_ev(b + 24, 0, '0, bitm(1));
      at(b + 23);
      check("clean_level_hold", level, bitm(1));
      at(b + 24);
      check("clean_level_down", level, '0);
      at(b + 26);

      // Bounce on button 2: high 2, low 1, then steady high.
      b = cyc;
      pb[2] = 1'b1;
      at(b + 2);
      pb[2] = 1'b0;
      at(b + 3);
      pb[2] = 1'b1;
      expect_ev(b + 8, 0, bitm(2), '0);
      at(b + 7);
      check("bounce_level_low", level, '0);
      at(b + 10);
      pb[2] = 1'b0;
      expect_ev(b + 15, 0, '0, bitm(2));
      at(b + 17);

      // Buttons 3 and 4 together.
      b = cyc;
      pb[3] = 1'b1;
      pb[4] = 1'b1;
      expect_ev(b + 5, 0, bitm(3) | bitm(4), '0);
      at(b + 5);
      check("pair_level", level, bitm(3) | bitm(4));
      at(b + 8);
      pb[3] = 1'b0;
      pb[4] = 1'b0;
      expect_ev(b + 13, 0, '0, bitm(3) | bitm(4));
      at(b + 15);

      // Reset while ARMING, then while PRESSED, with button 5 held.
      b = cyc;
      pb[5] = 1'b1;
      at(b + 3);
      reset = 1'b1;
      at(b + 4);
      check("rst_arm_level", level, '0);
      check("rst_arm_press", press, '0);
      check("rst_arm_release", pb_release, '0);
      reset = 1'b0;
      expect_ev(b + 9, 0, bitm(5), '0);
      at(b + 9);
      check("rst_arm_relevel", level, bitm(5));
      at(b + 11);
      reset = 1'b1;
      at(b + 12);
      check("rst_prs_level", level, '0);
      check("rst_prs_press", press, '0);
      reset = 1'b0;
      expect_ev(b + 17, 0, bitm(5), '0);
      at(b + 19);
      pb[5] = 1'b0;
      expect_ev(b + 24, 0, '0, bitm(5));
      at(b + 26);

      // Downstream sequencer: a glitch must not step it, two presses must.
      check("seq_start", W'(seq), '0);
      b = cyc;
      pb[1] = 1'b1;
      at(b + 2);
      pb[1] = 1'b0;
      at(b + 8);
      check("seq_glitch", W'(seq), '0);
      press_hold(1);
      press_hold(1);
      check("seq_two_steps", W'(seq), W'(2));

      // Auto-repeat on the second instance.
      b = cyc;
      pb_r = 1'b1;
      expect_ev(b + 5, 1, W'(1), '0);
      expect_ev(b + 25, 1, W'(1), '0);
      expect_ev(b + 30, 1, W'(1), '0);
      expect_ev(b + 35, 1, W'(1), '0);
      at(b + 30);
      check("rpt_level", W'(level_r), W'(1));
      at(b + 36);
      pb_r = 1'b0;
      expect_ev(b + 41, 1, '0, W'(1));
      at(b + 55);

      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL missing_strobes: got %0d still pending, required 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
